scan_ctrl: RTL and testbench

Row/PWM scan sequencer for the HUB75 LED panel, sitting directly upstream of the line renderer.
- Walks the row address and the PWM threshold in order.
- Starts the renderer for each line with a one-cycle begin pulse and waits for its done flag.
- Then blanks the panel, latches the shifted data, and displays the row for a fixed on-time.
- Flags the end of each full PWM frame.

---
 rtl/scan_ctrl_if.sv | 37 +++
 rtl/scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_scan_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_ctrl_if.sv
// Renderer handshake and HUB75 panel drive bundle for the scan sequencer.
// master = scan_ctrl side, slave = renderer/panel/test side.
interface scan_ctrl_if;
    logic       enable;
    logic       begin_out;
    logic       done_in;
    logic [4:0] addr;
    logic [6:0] pwm;
    logic [4:0] row_addr;
    logic       lat;
    logic       oe_n;
    logic       frame_done;

    modport master (
        input  enable,
        input  done_in,
        output begin_out,
        output addr,
        output pwm,
        output row_addr,
        output lat,
        output oe_n,
        output frame_done
    );

    modport slave (
        output enable,
        output done_in,
        input  begin_out,
        input  addr,
        input  pwm,
        input  row_addr,
        input  lat,
        input  oe_n,
        input  frame_done
    );
endinterface

// File: rtl/scan_ctrl.sv
// HUB75 row/PWM scan sequencer: kicks the line renderer, then blanks,
// latches and shows each row, stepping row address and PWM threshold.
module scan_ctrl #(
    parameter int ROWS         = 32,
    parameter int PWM_LEVELS   = 128,
    parameter int BLANK_CYCLES = 2,
    parameter int LATCH_CYCLES = 1,
    parameter int ON_CYCLES    = 64
) (
    input  logic        clk_25MHz,
    input  logic        rst,
    scan_ctrl_if.master bus
);

    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
    localparam logic [15:0] LATCH_LAST = 16'(LATCH_CYCLES - 1);
    localparam logic [15:0] ON_LAST    = 16'(ON_CYCLES - 1);
    localparam logic [31:0] ROWS_LAST  = 32'(ROWS - 1);
    localparam logic [31:0] PWM_LAST   = 32'(PWM_LEVELS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_BLANK = 3'd3,
        ST_LATCH = 3'd4,
        ST_SHOW  = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] cnt_r;
    logic [4:0]  addr_r;
    logic [6:0]  pwm_r;
    logic [4:0]  row_addr_r;
    logic        begin_r;
    logic        lat_r;
    logic        oe_n_r;
    logic        frame_done_r;

    logic        begin_nxt_s;
    logic        lat_nxt_s;
    logic        oe_n_nxt_s;
    logic        last_show_s;
    logic        addr_wrap_s;
    logic        pwm_wrap_s;

    assign last_show_s = (state_r == ST_SHOW) && (cnt_r == ON_LAST);
    assign addr_wrap_s = !({27'd0, addr_r} < ROWS_LAST);
    assign pwm_wrap_s  = !({25'd0, pwm_r} < PWM_LAST);

    // State register
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; the first SHIFT cycle (cnt_r == 0) ignores a stale done
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.enable) state_nxt_s = ST_START;
                else            state_nxt_s = ST_IDLE;
            end
            ST_START: begin
                state_nxt_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if ((cnt_r != 16'd0) && bus.done_in) state_nxt_s = ST_BLANK;
                else                                 state_nxt_s = ST_SHIFT;
            end
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) state_nxt_s = ST_LATCH;
                else                     state_nxt_s = ST_BLANK;
            end
            ST_LATCH: begin
                if (cnt_r == LATCH_LAST) state_nxt_s = ST_SHOW;
                else                     state_nxt_s = ST_LATCH;
            end
            ST_SHOW: begin
                if (cnt_r != ON_LAST)  state_nxt_s = ST_SHOW;
                else if (bus.enable)   state_nxt_s = ST_START;
                else                   state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so registered outputs line up with state_r
    always_comb begin
        begin_nxt_s = 1'b0;
        lat_nxt_s   = 1'b0;
        oe_n_nxt_s  = 1'b1;
        case (state_nxt_s)
            ST_START: begin_nxt_s = 1'b1;
            ST_LATCH: lat_nxt_s   = 1'b1;
            ST_SHOW:  oe_n_nxt_s  = 1'b0;
            default: begin
                begin_nxt_s = 1'b0;
                lat_nxt_s   = 1'b0;
                oe_n_nxt_s  = 1'b1;
            end
        endcase
    end

    // Per-state cycle counter; saturates so an endless SHIFT cannot re-arm the stale-done guard
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (state_nxt_s != state_r) begin
            cnt_r <= 16'd0;
        end else if (cnt_r != 16'hFFFF) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered outputs, row select capture and row/PWM advance
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            begin_r      <= 1'b0;
            lat_r        <= 1'b0;
            oe_n_r       <= 1'b1;
            frame_done_r <= 1'b0;
            addr_r       <= 5'd0;
            pwm_r        <= 7'd0;
            row_addr_r   <= 5'd0;
        end else begin
            begin_r      <= begin_nxt_s;
            lat_r        <= lat_nxt_s;
            oe_n_r       <= oe_n_nxt_s;
            frame_done_r <= last_show_s && addr_wrap_s && pwm_wrap_s;
            if ((state_r != ST_LATCH) && (state_nxt_s == ST_LATCH)) begin
                row_addr_r <= addr_r;
            end else begin
                row_addr_r <= row_addr_r;
            end
            if (last_show_s) begin
                if (!addr_wrap_s) begin
                    addr_r <= addr_r + 5'd1;
                    pwm_r  <= pwm_r;
                end else begin
                    addr_r <= 5'd0;
                    if (!pwm_wrap_s) pwm_r <= pwm_r + 7'd1;
                    else             pwm_r <= 7'd0;
                end
            end else begin
                addr_r <= addr_r;
                pwm_r  <= pwm_r;
            end
        end
    end

    assign bus.begin_out  = begin_r;
    assign bus.addr       = addr_r;
    assign bus.pwm        = pwm_r;
    assign bus.row_addr   = row_addr_r;
    assign bus.lat        = lat_r;
    assign bus.oe_n       = oe_n_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: renderer model with random done latency, line timing
// and row/PWM sequence checked against the per-line cycle formula.
module tb_scan_ctrl;
    localparam int ROWS  = 4;
    localparam int PWM   = 3;
    localparam int BLANK = 2;
    localparam int LATCH = 1;
    localparam int ON    = 4;

    logic clk_25MHz = 1'b0;
    logic rst       = 1'b0;

    scan_ctrl_if bus();

    scan_ctrl #(
        .ROWS(ROWS), .PWM_LEVELS(PWM), .BLANK_CYCLES(BLANK),
        .LATCH_CYCLES(LATCH), .ON_CYCLES(ON)
    ) dut (
        .clk_25MHz(clk_25MHz),
        .rst(rst),
        .bus(bus)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    int n_tests = 0;
    int n_fail  = 0;
    // 0: done k cycles after begin, 1: done held high, 2: never done
    int rend_mode = 0;
    int rend_k    = 0;
    int k_last    = 0;
    int rend_cnt  = 0;
    bit rend_busy = 1'b0;

    // Renderer model, acting on the falling edge
    initial begin
        bus.done_in = 1'b0;
        forever begin
            @(negedge clk_25MHz);
            if (rst) begin
                bus.done_in = 1'b0;
                rend_busy   = 1'b0;
            end else if (rend_mode == 1) begin
                bus.done_in = 1'b1;
                if (bus.begin_out) k_last = 0;
            end else if (bus.begin_out) begin
                bus.done_in = 1'b0;
                rend_cnt    = (rend_k > 0) ? rend_k : int'($urandom_range(1, 12));
                k_last      = rend_cnt;
                rend_busy   = (rend_mode == 0);
            end else if (rend_busy) begin
                rend_cnt = rend_cnt - 1;
                if (rend_cnt == 0) begin
                    bus.done_in = 1'b1;
                    rend_busy   = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_25MHz);
        #2;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.enable = 1'b0;
        rend_mode  = 0;
        rend_k     = 0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic wait_begin(input int limit, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus.begin_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_begin_timeout: got no begin_out within %0d cycles, required one", nm, limit);
        end
    endtask

    // Called in the begin_out cycle; ends on the cycle after the last SHOW cycle
    task automatic measure_line(input logic [4:0] ea, input logic [6:0] ep,
                                input bit ef, input bit drop, input string nm);
        int s, lat_t, per;
        int lat_first = -1, lat_cnt = 0, oe_first = -1, oe_cnt = 0;
        int beg_cnt = 0, fd_cnt = 0, unstable = 0;
        logic [4:0] ra_show = 5'h1f;
        n_tests++;
        if (bus.addr !== ea || bus.pwm !== ep) begin
            n_fail++;
            $display("FAIL %s_start_addr_pwm: got addr=%0d pwm=%0d required addr=%0d pwm=%0d",
                     nm, bus.addr, bus.pwm, ea, ep);
        end
        step();
        if (drop) bus.enable = 1'b0;
        s     = (k_last > 2) ? k_last : 2;
        lat_t = 1 + s + BLANK;
        per   = lat_t + LATCH + ON;
        for (int t = 1; t < per; t++) begin
            if (bus.begin_out) beg_cnt++;
            if (bus.frame_done) fd_cnt++;
            if (bus.lat) begin
                if (lat_first < 0) lat_first = t;
                lat_cnt++;
            end
            if (!bus.oe_n) begin
                if (oe_first < 0) oe_first = t;
                oe_cnt++;
                ra_show = bus.row_addr;
            end
            if (t < lat_t + LATCH && (bus.addr !== ea || bus.pwm !== ep)) unstable++;
            step();
        end
        n_tests++;
        if (beg_cnt !== 0) begin
            n_fail++;
            $display("FAIL %s_begin_width: got %0d extra begin cycles, required 0", nm, beg_cnt);
        end
        n_tests++;
        if (lat_first !== lat_t || lat_cnt !== LATCH) begin
            n_fail++;
            $display("FAIL %s_lat: got offset %0d width %0d, required offset %0d width %0d",
                     nm, lat_first, lat_cnt, lat_t, LATCH);
        end
        n_tests++;
        if (oe_first !== lat_t + LATCH || oe_cnt !== ON) begin
            n_fail++;
            $display("FAIL %s_oe_n: got low at %0d for %0d cycles, required at %0d for %0d",
                     nm, oe_first, oe_cnt, lat_t + LATCH, ON);
        end
        n_tests++;
        if (ra_show !== ea) begin
            n_fail++;
            $display("FAIL %s_row_addr: got %0d required %0d", nm, ra_show, ea);
        end
        n_tests++;
        if (unstable !== 0) begin
            n_fail++;
            $display("FAIL %s_addr_stable: got %0d unstable cycles, required 0", nm, unstable);
        end
        n_tests++;
        if (fd_cnt !== 0 || bus.frame_done !== ef) begin
            n_fail++;
            $display("FAIL %s_frame_done: got %0d early pulses, end=%0b, required 0 and %0b",
                     nm, fd_cnt, bus.frame_done, ef);
        end
        n_tests++;
        if (bus.begin_out !== !drop || bus.oe_n !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_period: got begin_out=%0b oe_n=%0b at cycle %0d, required %0b and 1",
                     nm, bus.begin_out, bus.oe_n, per, !drop);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        bus.enable = 1'b0;
        #1;
        n_tests++;
        if ({bus.begin_out, bus.lat, bus.oe_n, bus.frame_done} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_ctrl: got begin,lat,oe_n,frame=%b required 0010",
                     {bus.begin_out, bus.lat, bus.oe_n, bus.frame_done});
        end
        n_tests++;
        if (bus.addr !== 5'd0 || bus.pwm !== 7'd0 || bus.row_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got addr=%0d pwm=%0d row=%0d required 0 0 0",
                     bus.addr, bus.pwm, bus.row_addr);
        end
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        n_tests++;
        if (bus.begin_out !== 1'b0 || bus.oe_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: got begin=%0b oe_n=%0b with enable low, required 0 1",
                     bus.begin_out, bus.oe_n);
        end
    endtask

    task automatic test_single_line();
        do_reset();
        rend_k     = 10;
        bus.enable = 1'b1;
        wait_begin(5, "single");
        measure_line(5'd0, 7'd0, 1'b0, 1'b0, "single");
    endtask

    task automatic test_stale_done();
        do_reset();
        rend_mode  = 1;
        bus.enable = 1'b1;
        wait_begin(5, "stale");
        measure_line(5'd0, 7'd0, 1'b0, 1'b0, "stale0");
        measure_line(5'd1, 7'd0, 1'b0, 1'b0, "stale1");
    endtask

    task automatic test_frame();
        do_reset();
        bus.enable = 1'b1;
        wait_begin(5, "frame");
        for (int i = 0; i < 15; i++) begin
            measure_line(5'(i % ROWS), 7'((i / ROWS) % PWM),
                         (i == ROWS * PWM - 1), 1'b0, $sformatf("frame_l%0d", i));
        end
    endtask

    task automatic test_enable_drop();
        int bad = 0;
        do_reset();
        bus.enable = 1'b1;
        wait_begin(5, "drop");
        measure_line(5'd0, 7'd0, 1'b0, 1'b0, "drop_l0");
        measure_line(5'd1, 7'd0, 1'b0, 1'b0, "drop_l1");
        measure_line(5'd2, 7'd0, 1'b0, 1'b1, "drop_l2");
        for (int i = 0; i < 10; i++) begin
            if (bus.begin_out !== 1'b0 || bus.oe_n !== 1'b1 || bus.addr !== 5'd3) bad++;
            step();
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL drop_idle: got %0d bad idle cycles, required 0 (addr=%0d)", bad, bus.addr);
        end
        bus.enable = 1'b1;
        wait_begin(5, "drop_resume");
        n_tests++;
        if (bus.addr !== 5'd3 || bus.pwm !== 7'd0) begin
            n_fail++;
            $display("FAIL drop_resume_addr: got addr=%0d pwm=%0d required 3 0", bus.addr, bus.pwm);
        end
    endtask

    task automatic test_stall();
        int  bad  = 0;
        bit  seen = 1'b0;
        do_reset();
        rend_mode  = 2;
        bus.enable = 1'b1;
        wait_begin(5, "stall");
        for (int i = 0; i < 500; i++) begin
            step();
            if (bus.begin_out !== 1'b0 || bus.lat !== 1'b0 || bus.oe_n !== 1'b1) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d active cycles during stall, required 0", bad);
        end
        rend_mode = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.lat === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL stall_resume: got no lat after done, required lat");
        end
    endtask

    task automatic test_reset_mid_show();
        bit found = 1'b0;
        do_reset();
        bus.enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (bus.oe_n === 1'b0 && bus.row_addr === 5'd2) begin
                found = 1'b1;
                break;
            end
            step();
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL midrst_reach: got no SHOW of row 2, required one");
        end
        #5 rst = 1'b1;
        #1;
        n_tests++;
        if (bus.oe_n !== 1'b1 || bus.lat !== 1'b0 || bus.begin_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ctrl: got oe_n=%0b lat=%0b begin=%0b required 1 0 0",
                     bus.oe_n, bus.lat, bus.begin_out);
        end
        n_tests++;
        if (bus.addr !== 5'd0 || bus.pwm !== 7'd0 || bus.row_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL midrst_addr: got addr=%0d pwm=%0d row=%0d required 0 0 0",
                     bus.addr, bus.pwm, bus.row_addr);
        end
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.enable = 1'b0;
        test_reset();
        test_single_line();
        test_stale_done();
        test_frame();
        test_enable_drop();
        test_stall();
        test_reset_mid_show();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
